// File: rtl/prod_accum_pkg.sv
// prod_accum_pkg: shared widths, defaults, FSM state type and a clog2 helper
// for the product accumulator that sits behind the 8x8 multiplier.
// Optional overflow tracking in prod_accum is enabled by PROD_ACCUM_OVF_EN.
package prod_accum_pkg;

  // Multiplier output width, shared with the multiplier block.
  localparam int PROD_W    = 16;
  // Default products per frame.
  localparam int N_DEF     = 4;
  // Default accumulator / result width.
  localparam int ACC_W_DEF = 20;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/prod_accum_if.sv
// prod_accum_if: product input stream, frame result stream and frame clear.
// slave  = accumulator side, master = multiplier / consumer side.
interface prod_accum_if
  import prod_accum_pkg::*;
#(
  parameter int PW    = PROD_W,
  parameter int ACC_W = ACC_W_DEF
) ();

  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    in_prod;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport slave (
    input  clr, in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

  modport master (
    output clr, in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

endinterface

// File: rtl/prod_accum.sv
// prod_accum: sums N accepted products into one frame result and holds it on
// a valid/ready output. The result register doubles as the DONE holding
// buffer; in_ready follows out_ready in DONE so a draining result and the
// first product of the next frame can share a cycle.
// Define PROD_ACCUM_OVF_EN to build the per-frame sticky carry driving out_ovf;
// otherwise out_ovf is tied low. The sum wraps modulo 2^ACC_W either way.
// The bus interface must be instantiated with the same PW / ACC_W.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int PW    = PROD_W,
  parameter int N     = N_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input logic          clk,
  input logic          rst,
  prod_accum_if.slave  bus
);

  localparam int            CW   = clog2_min1(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             ov_q, ov_n;
  logic [ACC_W-1:0] sum_q, sum_n;
  logic             rdy;
  logic             accept;
  logic             last;
  logic [ACC_W-1:0] add;

  // Acc is already zero in DONE, so one adder serves both mid-frame and
  // frame-start accepts.
`ifdef PROD_ACCUM_OVF_EN
  localparam int AW1 = ACC_W + 1;
  logic [ACC_W:0] add_full;
  logic           carry;
  logic           ovf, ovf_n;
  logic           oovf_q, oovf_n;

  assign add_full = {1'b0, acc} + AW1'(bus.in_prod);
  assign add      = add_full[ACC_W-1:0];
  assign carry    = add_full[ACC_W];
`else
  assign add      = acc + ACC_W'(bus.in_prod);
`endif

  // clr blocks acceptance; in DONE a product is only taken while the result drains.
  assign rdy    = !bus.clr && ((state == ACCUM) || bus.out_ready);
  assign accept = bus.in_valid && rdy;
  assign last   = (cnt == LAST);

  // Next-state: clr first, then accept (complete or continue), then drain.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    ov_n    = ov_q;
    sum_n   = sum_q;
`ifdef PROD_ACCUM_OVF_EN
    ovf_n   = ovf;
    oovf_n  = oovf_q;
`endif
    if (bus.clr) begin
      state_n = ACCUM;
      acc_n   = '0;
      cnt_n   = '0;
      ov_n    = 1'b0;
`ifdef PROD_ACCUM_OVF_EN
      ovf_n   = 1'b0;
      oovf_n  = 1'b0;
`endif
    end else if (accept) begin
      if (last) begin
        // Frame complete: publish result and rearm the accumulator.
        state_n = DONE;
        sum_n   = add;
        ov_n    = 1'b1;
        acc_n   = '0;
        cnt_n   = '0;
`ifdef PROD_ACCUM_OVF_EN
        oovf_n  = ovf | carry;
        ovf_n   = 1'b0;
`endif
      end else begin
        // Mid-frame, or first element while the previous result drains.
        state_n = ACCUM;
        ov_n    = 1'b0;
        acc_n   = add;
        cnt_n   = cnt + 1'b1;
`ifdef PROD_ACCUM_OVF_EN
        ovf_n   = ovf | carry;
`endif
      end
    end else if ((state == DONE) && bus.out_ready) begin
      state_n = ACCUM;
      ov_n    = 1'b0;
    end
  end

  // State and datapath registers; rst discards any partial frame at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ov_q  <= 1'b0;
      sum_q <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      ov_q  <= ov_n;
      sum_q <= sum_n;
    end
  end

`ifdef PROD_ACCUM_OVF_EN
  // Sticky frame carry and its published copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf    <= 1'b0;
      oovf_q <= 1'b0;
    end else begin
      ovf    <= ovf_n;
      oovf_q <= oovf_n;
    end
  end

  assign bus.out_ovf = oovf_q;
`else
  assign bus.out_ovf = 1'b0;
`endif

  assign bus.in_ready  = rdy;
  assign bus.out_valid = ov_q;
  assign bus.out_sum   = sum_q;

endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: directed table of per-cycle vectors for an N=4/ACC_W=20
// accumulator, a mirrored N=4/ACC_W=16 instance for the wrap/overflow frame,
// and hand sequences for async reset and an N=1 instance.
module tb_prod_accum;
  import prod_accum_pkg::*;

`ifdef PROD_ACCUM_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  prod_accum_if #(.PW(16), .ACC_W(20)) bus0 ();
  prod_accum_if #(.PW(16), .ACC_W(16)) bus1 ();
  prod_accum_if #(.PW(16), .ACC_W(20)) bus2 ();

  prod_accum #(.PW(16), .N(4), .ACC_W(20)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  prod_accum #(.PW(16), .N(4), .ACC_W(16)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  prod_accum #(.PW(16), .N(1), .ACC_W(20)) u2 (.clk(clk), .rst(rst), .bus(bus2));

  // u1 sees exactly the u0 stimulus.
  assign bus1.clr       = bus0.clr;
  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_prod   = bus0.in_prod;
  assign bus1.out_ready = bus0.out_ready;

  typedef struct {
    logic        v;
    logic [15:0] p;
    logic        o;
    logic        c;
    logic        e_rdy;
    logic        e_ov;
    logic [19:0] e_sum;
    logic        c1;
    logic [15:0] e1_sum;
    logic        e1_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit v, int p, bit o, bit c, bit er, bit eo, int es,
                              bit c1 = 0, int e1 = 0, bit e1o = 0);
    vec_t r;
    r.v = v; r.p = 16'(p); r.o = o; r.c = c;
    r.e_rdy = er; r.e_ov = eo; r.e_sum = 20'(es);
    r.c1 = c1; r.e1_sum = 16'(e1); r.e1_ovf = e1o;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic put(input logic v, input int p, input logic o);
    bus0.in_valid  = v;
    bus0.in_prod   = 16'(p);
    bus0.out_ready = o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.clr = 0; bus0.in_valid = 0; bus0.in_prod = 0; bus0.out_ready = 0;
    bus2.clr = 0; bus2.in_valid = 0; bus2.in_prod = 0; bus2.out_ready = 0;

    // Frame 7592, then 4 x 65025 with back-pressure, drain+restart with 2448.
    tbl.push_back(mk(1, 322,  1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 352,  1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 855,  1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 6063, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0,    1, 0, 1, 1, 7592, 1, 7592, 0));
    tbl.push_back(mk(0, 0,    1, 0, 1, 0, 7592));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 65025, 1, 0, 1, 0, 7592));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(1, 999, 0, 0, 0, 1, 260100, 1, 63492, OVF_ON));
    tbl.push_back(mk(1, 2448, 1, 0, 1, 1, 260100, 1, 63492, OVF_ON));
    tbl.push_back(mk(1, 1,    1, 0, 1, 0, 260100));
    tbl.push_back(mk(1, 2,    1, 0, 1, 0, 260100));
    tbl.push_back(mk(1, 3,    1, 0, 1, 0, 260100));
    tbl.push_back(mk(0, 0,    1, 0, 1, 1, 2454));
    // Gapped input 1,0,0,1,0,1,1 with junk on idle cycles.
    tbl.push_back(mk(1, 10,   1, 0, 1, 0, 2454));
    tbl.push_back(mk(0, 777,  1, 0, 1, 0, 2454));
    tbl.push_back(mk(0, 777,  1, 0, 1, 0, 2454));
    tbl.push_back(mk(1, 20,   1, 0, 1, 0, 2454));
    tbl.push_back(mk(0, 777,  1, 0, 1, 0, 2454));
    tbl.push_back(mk(1, 30,   1, 0, 1, 0, 2454));
    tbl.push_back(mk(1, 40,   1, 0, 1, 0, 2454));
    tbl.push_back(mk(0, 0,    0, 0, 0, 1, 100));
    tbl.push_back(mk(0, 0,    1, 0, 1, 1, 100));
    tbl.push_back(mk(0, 0,    1, 0, 1, 0, 100));
    // clr after two products, then 4 x 1; clr while DONE keeps out_sum.
    tbl.push_back(mk(1, 322,  1, 0, 1, 0, 100));
    tbl.push_back(mk(1, 352,  1, 0, 1, 0, 100));
    tbl.push_back(mk(1, 5,    1, 1, 0, 0, 100));
    for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 1, 1, 0, 1, 0, 100));
    tbl.push_back(mk(0, 0,    0, 1, 0, 1, 4));
    tbl.push_back(mk(0, 0,    0, 0, 1, 0, 4));

    // Reset state.
    #12;
    chk("rst out_valid", 32'(bus0.out_valid), 0);
    chk("rst in_ready",  32'(bus0.in_ready),  1);
    chk("rst out_sum",   32'(bus0.out_sum),   0);
    chk("rst out_ovf",   32'(bus0.out_ovf),   0);
    chk("rst n1 out_valid", 32'(bus2.out_valid), 0);
    @(posedge clk); #1;
    rst = 0;

    foreach (tbl[i]) begin
      bus0.in_valid  = tbl[i].v;
      bus0.in_prod   = tbl[i].p;
      bus0.out_ready = tbl[i].o;
      bus0.clr       = tbl[i].c;
      @(negedge clk);
      chk($sformatf("r%0d in_ready", i),  32'(bus0.in_ready),  32'(tbl[i].e_rdy));
      chk($sformatf("r%0d out_valid", i), 32'(bus0.out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("r%0d out_sum", i),   32'(bus0.out_sum),   32'(tbl[i].e_sum));
      chk($sformatf("r%0d out_ovf", i),   32'(bus0.out_ovf),   0);
      if (tbl[i].c1) begin
        chk($sformatf("r%0d w16 out_valid", i), 32'(bus1.out_valid), 1);
        chk($sformatf("r%0d w16 out_sum", i),   32'(bus1.out_sum),   32'(tbl[i].e1_sum));
        chk($sformatf("r%0d w16 out_ovf", i),   32'(bus1.out_ovf),   32'(tbl[i].e1_ovf));
      end
      @(posedge clk); #1;
    end
    bus0.clr = 0;

    // Async reset while a result is held.
    for (int k = 0; k < 4; k++) put(1, 5, 0);
    bus0.in_valid = 0;
    @(negedge clk);
    chk("hold out_valid", 32'(bus0.out_valid), 1);
    chk("hold out_sum",   32'(bus0.out_sum),   20);
    #2 rst = 1;
    #1;
    chk("arst out_valid", 32'(bus0.out_valid), 0);
    chk("arst in_ready",  32'(bus0.in_ready),  1);
    chk("arst out_sum",   32'(bus0.out_sum),   0);
    #1 rst = 0;
    @(posedge clk); #1;

    // Async reset mid-frame discards the partial sum.
    put(1, 50, 1);
    put(1, 60, 1);
    bus0.in_valid = 0;
    @(negedge clk);
    #1 rst = 1;
    #1;
    chk("arst2 out_valid", 32'(bus0.out_valid), 0);
    chk("arst2 in_ready",  32'(bus0.in_ready),  1);
    #1 rst = 0;
    @(posedge clk); #1;
    put(1, 1, 1); put(1, 2, 1); put(1, 3, 1); put(1, 4, 1);
    bus0.in_valid = 0;
    @(negedge clk);
    chk("post-rst out_valid", 32'(bus0.out_valid), 1);
    chk("post-rst out_sum",   32'(bus0.out_sum),   10);

    // N=1: one result per accepted product at full rate.
    @(posedge clk); #1;
    bus2.out_ready = 1;
    for (int k = 5; k <= 7; k++) begin
      bus2.in_valid = 1;
      bus2.in_prod  = 16'(k);
      @(posedge clk); #1;
      chk($sformatf("n1 out_valid %0d", k), 32'(bus2.out_valid), 1);
      chk($sformatf("n1 out_sum %0d", k),   32'(bus2.out_sum),   32'(k));
    end
    bus2.out_ready = 0;
    bus2.in_prod   = 16'd9;
    #1;
    chk("n1 bp in_ready", 32'(bus2.in_ready), 0);
    @(posedge clk); #1;
    chk("n1 bp out_sum",   32'(bus2.out_sum),   7);
    chk("n1 bp out_valid", 32'(bus2.out_valid), 1);
    bus2.out_ready = 1;
    #1;
    chk("n1 drain in_ready", 32'(bus2.in_ready), 1);
    @(posedge clk); #1;
    chk("n1 drain out_sum",   32'(bus2.out_sum),   9);
    chk("n1 drain out_valid", 32'(bus2.out_valid), 1);
    bus2.in_valid = 0;
    @(posedge clk); #1;
    chk("n1 idle out_valid", 32'(bus2.out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
